// File: rtl/pipe_reg_chain.sv
// Elastic DEPTH-stage register chain with valid/ready handshake, bubble collapse and flush.
// Each stage is one pipe_reg_stage; stage DEPTH-1 drives the output side.

module pipe_reg_stage #(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] INIT  = {WIDTH{1'b0}}
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             ready,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  output logic             v,
  output logic [WIDTH-1:0] d
);
  logic             v_d, v_q;
  logic [WIDTH-1:0] d_d, d_q;

  // Data only moves with a valid word; an empty stage keeps stale data hidden behind v=0.
  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (flush) begin
      v_d = 1'b0;
      d_d = INIT;
    end else if (ready) begin
      v_d = up_valid;
      if (up_valid) d_d = up_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      v_q <= 1'b0;
      d_q <= INIT;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

  assign v = v_q;
  assign d = d_q;
endmodule

module pipe_reg_chain #(
  parameter int               WIDTH = 32,
  parameter int               DEPTH = 2,
  parameter logic [WIDTH-1:0] INIT  = {WIDTH{1'b0}},
  localparam int              CW    = $clog2(DEPTH+1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count
);
  if (DEPTH < 1) begin : g_bad_depth
    $error("pipe_reg_chain: DEPTH must be >= 1");
  end

  logic [DEPTH-1:0]            vld_pipe;
  logic [DEPTH-1:0][WIDTH-1:0] dat_pipe;
  logic [DEPTH-1:0]            rdy;
  logic                        in_xfer, out_xfer;
  logic                        rst_rel_d, rst_rel_q;
  logic [CW-1:0]               count_d, count_q;

  // Stage i may load if any stage from i to the output is empty, or the output drains.
  always_comb begin
    logic hole;
    hole = 1'b0;
    rdy  = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      hole   = hole | ~vld_pipe[i];
      rdy[i] = hole | out_ready;
    end
  end

  // Input is refused until the first clock edge after reset is released.
  assign in_ready  = rdy[0] & ~flush & rst_rel_q;
  assign in_xfer   = in_valid & in_ready;
  assign out_valid = vld_pipe[DEPTH-1];
  assign out_data  = dat_pipe[DEPTH-1];
  assign out_xfer  = out_valid & out_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             up_v;
    logic [WIDTH-1:0] up_d;
    if (i == 0) begin : g_head
      assign up_v = in_xfer;
      assign up_d = in_data;
    end else begin : g_body
      assign up_v = vld_pipe[i-1];
      assign up_d = dat_pipe[i-1];
    end
    pipe_reg_stage #(.WIDTH(WIDTH), .INIT(INIT)) u_stage (
      .clock    (clock),
      .reset    (reset),
      .flush    (flush),
      .ready    (rdy[i]),
      .up_valid (up_v),
      .up_data  (up_d),
      .v        (vld_pipe[i]),
      .d        (dat_pipe[i])
    );
  end

  always_comb begin
    rst_rel_d = 1'b1;
    count_d   = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      case ({in_xfer, out_xfer})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rst_rel_q <= 1'b0;
      count_q   <= '0;
    end else begin
      rst_rel_q <= rst_rel_d;
      count_q   <= count_d;
    end
  end

  assign count = count_q;
endmodule
